rgb_phase_decoder: RTL and testbench
====================================

Name: rgb_phase_decoder

Overview:
- Receive-side checker for the two-lamp RGB traffic-light sequencer; watches the six LED drive lines (led4_r/g/b, led5_r/g/b) and reconstructs the current phase.
- Measures each phase's dwell in tick units and flags illegal colour patterns, out-of-order phases and wrong dwell times.
- Sits beside the sequencer on the same clock; its outputs feed a status display and the verification scoreboard.

Parameters:
- LONG_TICKS, 5, required dwell of phases P1 and P4, in ticks.
- SHORT_TICKS, 1, required dwell of phases P2, P3, P5 and P6, in ticks.
- CNT_W, 4, dwell counter width.
- STUCK_TICKS, 8, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle timebase strobe, the same strobe that paces the sequencer.
- led4_r, led4_g, led4_b, led5_r, led5_g, led5_b  in  1 each  observed LED drive lines.
- err_clr  in  1  one-cycle pulse; clears all sticky errors.
- phase  out  3  decoded phase: 0=OFF, 1..6=P1..P6, 7=ERR.
- phase_chg  out  1  one-cycle pulse when phase changes.
- dwell_cnt  out  CNT_W  ticks spent in the current phase, saturating.
- cycle_cnt  out  8  number of completed P6->P1 cycles; wraps at 255->0.
- err_illegal, err_seq, err_timing, err_stuck  out  1 each  sticky error flags.

Behaviour:
- Reset is asynchronous, active-high: one clock, reset is asynchronous and active-high. While rst is high, every register and every output is 0, and the state is IDLE.
- Input stage: the six LED lines are registered every clk into pat[5:0] and pat_d holds the previous pat. A pattern change means pat != pat_d.
- Classification of pat, combinational:
  - all zero -> OFF.
  - 4R, 5G -> P1.
  - 4R, 5R+G -> P2.
  - 4R, 5R -> BOTHRED.
  - 4G, 5R -> P4.
  - 4R+G, 5R -> P5.
  - any blue bit set, or any other combination -> ILLEGAL.
- States: IDLE(0), P1..P6(1..6), ERR(7). phase equals the state code.
- Transitions are evaluated only on a cycle where the pattern changes.
  - Legal successors: IDLE->P1, P1->P2, P2->P3, P3->P4, P4->P5, P5->P6, P6->P1. Any state -> IDLE on OFF, with no error.
  - BOTHRED resolves to P3 when the state is P2 and to P6 when the state is P5. From any other state it is a sequence error.
  - ILLEGAL -> state ERR and err_illegal set.
  - Any other non-successor -> state ERR and err_seq set.
  - ERR exits only to IDLE, on OFF.
- Latency: an LED change sampled at edge k appears in pat at k; phase and phase_chg update at edge k+1.
- dwell_cnt is cleared to 0 on the edge the phase changes. Otherwise it increments on tick and saturates at 2^CNT_W-1. A tick coinciding with a phase change is dropped, and the count restarts at 0.
- Timing check: on leaving P1..P6 to its legal successor, err_timing is set if dwell_cnt != the required dwell for that phase. No check on leaving IDLE or ERR, or on a transition to IDLE.
- cycle_cnt increments on every P6->P1 transition.
- Sticky errors hold until err_clr. If err_clr and a new error occur in the same cycle, the new error wins and its flag remains 1.
- rst asserted mid-phase: immediate return to IDLE with all counters 0. After release, the first non-OFF pattern must be P1 or err_seq is raised.

Optional Feature:
- Macro: RGB_DEC_STUCK_EN.
- Defined: a watchdog sets err_stuck when dwell_cnt reaches STUCK_TICKS in any state P1..P6. The watchdog is not active in IDLE or ERR, and the state is unchanged when it fires.
- Undefined: err_stuck is constant 0 and no watchdog logic is built.

Test Plan:
- Nominal cycle, with tick every 4 clk: P1 for 5 ticks, P2 1, P3 1, P4 5, P5 1, P6 1, back to P1 -> phase steps 1..6 then 1, one phase_chg per step, no errors, cycle_cnt=1.
- Set led4_b=1 during P2 -> phase=7 two clk later and err_illegal=1; drive all-off -> phase=0; pulse err_clr -> err_illegal=0.
- Jump from P1 directly to BOTHRED -> phase=7, err_seq=1, err_illegal=0.
- Hold P1 for only 3 ticks, then go to P2 -> phase=2 and err_timing=1. Pulse err_clr in the same cycle as a new error -> flag stays 1.
- Assert rst in P4 with dwell_cnt=3 -> all outputs 0 immediately. Release, present P2 first -> err_seq=1.
- With RGB_DEC_STUCK_EN defined, hold P4 for 8 ticks -> err_stuck=1 at the 8th tick while phase stays 4. With it undefined, err_stuck stays 0.

Source files
------------

// File: rtl/rgb_phase_decoder.sv
// Receive-side phase decoder/checker for the two-lamp RGB traffic-light sequencer.
// Optional stuck-phase watchdog built only when RGB_DEC_STUCK_EN is defined.
module rgb_phase_decoder #(
  parameter int LONG_TICKS  = 5,
  parameter int SHORT_TICKS = 1,
  parameter int CNT_W       = 4
`ifdef RGB_DEC_STUCK_EN
  ,
  parameter int STUCK_TICKS = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             led4_r,
  input  logic             led4_g,
  input  logic             led4_b,
  input  logic             led5_r,
  input  logic             led5_g,
  input  logic             led5_b,
  input  logic             err_clr,
  output logic [2:0]       phase,
  output logic             phase_chg,
  output logic [CNT_W-1:0] dwell_cnt,
  output logic [7:0]       cycle_cnt,
  output logic             err_illegal,
  output logic             err_seq,
  output logic             err_timing,
  output logic             err_stuck
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_P4   = 3'd4,
    S_P5   = 3'd5,
    S_P6   = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_OFF = 3'd0,
    C_P1  = 3'd1,
    C_P2  = 3'd2,
    C_BR  = 3'd3,
    C_P4  = 3'd4,
    C_P5  = 3'd5,
    C_ILL = 3'd6
  } pat_class_t;

  localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};

  // Pattern bit order: {4R, 4G, 4B, 5R, 5G, 5B}
  function automatic pat_class_t classify(input logic [5:0] p);
    case (p)
      6'b000_000: classify = C_OFF;
      6'b100_010: classify = C_P1;
      6'b100_110: classify = C_P2;
      6'b100_100: classify = C_BR;
      6'b010_100: classify = C_P4;
      6'b110_100: classify = C_P5;
      default:    classify = C_ILL;
    endcase
  endfunction

  function automatic state_t successor(input state_t s);
    case (s)
      S_IDLE:  successor = S_P1;
      S_P1:    successor = S_P2;
      S_P2:    successor = S_P3;
      S_P3:    successor = S_P4;
      S_P4:    successor = S_P5;
      S_P5:    successor = S_P6;
      S_P6:    successor = S_P1;
      default: successor = S_IDLE;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] required_dwell(input state_t s);
    case (s)
      S_P1, S_P4: required_dwell = CNT_W'(LONG_TICKS);
      default:    required_dwell = CNT_W'(SHORT_TICKS);
    endcase
  endfunction

  logic [5:0]       pat_r;
  logic [5:0]       pat_d_r;
  state_t           state_r;
  logic [CNT_W-1:0] dwell_cnt_r;

  logic             pat_chg_s;
  pat_class_t       class_s;
  state_t           target_s;
  state_t           next_state_s;
  logic             legal_s;
  logic             set_ill_s;
  logic             set_seq_s;
  logic             set_timing_s;
  logic             phase_chg_s;
  logic             wrap_s;
  logic             in_phase_s;
  logic [CNT_W-1:0] dwell_nxt_s;

  // Input stage: capture LED lines and keep the previous sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r   <= 6'b000000;
      pat_d_r <= 6'b000000;
    end else begin
      pat_r   <= {led4_r, led4_g, led4_b, led5_r, led5_g, led5_b};
      pat_d_r <= pat_r;
    end
  end

  assign pat_chg_s  = (pat_r != pat_d_r);
  assign class_s    = classify(pat_r);
  assign in_phase_s = (state_r != S_IDLE) && (state_r != S_ERR);

  // Map the observed pattern to the phase it claims to be; BOTHRED depends on context
  always_comb begin
    target_s = S_ERR;
    case (class_s)
      C_P1: target_s = S_P1;
      C_P2: target_s = S_P2;
      C_P4: target_s = S_P4;
      C_P5: target_s = S_P5;
      C_BR: begin
        if (state_r == S_P2) begin
          target_s = S_P3;
        end else if (state_r == S_P5) begin
          target_s = S_P6;
        end else begin
          target_s = S_ERR;
        end
      end
      default: target_s = S_ERR;
    endcase
  end

  // Next-state and error-event decision, evaluated only on a pattern change
  always_comb begin
    next_state_s = state_r;
    legal_s      = 1'b0;
    set_ill_s    = 1'b0;
    set_seq_s    = 1'b0;
    if (pat_chg_s) begin
      case (class_s)
        C_OFF: next_state_s = S_IDLE;
        C_ILL: begin
          next_state_s = S_ERR;
          set_ill_s    = 1'b1;
        end
        default: begin
          if (state_r == S_ERR) begin
            next_state_s = S_ERR;
          end else if (target_s == successor(state_r)) begin
            next_state_s = target_s;
            legal_s      = 1'b1;
          end else begin
            next_state_s = S_ERR;
            set_seq_s    = 1'b1;
          end
        end
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  assign set_timing_s = legal_s && in_phase_s && (dwell_cnt_r != required_dwell(state_r));
  assign phase_chg_s  = (next_state_s != state_r);
  assign wrap_s       = legal_s && (state_r == S_P6);

  // Dwell counter: restarts on a phase change, a coincident tick is dropped
  always_comb begin
    dwell_nxt_s = dwell_cnt_r;
    if (phase_chg_s) begin
      dwell_nxt_s = {CNT_W{1'b0}};
    end else if (tick && (dwell_cnt_r != DWELL_MAX)) begin
      dwell_nxt_s = dwell_cnt_r + CNT_W'(1);
    end else begin
      dwell_nxt_s = dwell_cnt_r;
    end
  end

  // Phase FSM with registered status outputs and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      phase_chg   <= 1'b0;
      dwell_cnt_r <= {CNT_W{1'b0}};
      cycle_cnt   <= 8'd0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_timing  <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      phase_chg   <= phase_chg_s;
      dwell_cnt_r <= dwell_nxt_s;
      cycle_cnt   <= wrap_s ? cycle_cnt + 8'd1 : cycle_cnt;
      // A new error outranks a simultaneous clear
      err_illegal <= set_ill_s    ? 1'b1 : (err_clr ? 1'b0 : err_illegal);
      err_seq     <= set_seq_s    ? 1'b1 : (err_clr ? 1'b0 : err_seq);
      err_timing  <= set_timing_s ? 1'b1 : (err_clr ? 1'b0 : err_timing);
    end
  end

  assign phase     = state_r;
  assign dwell_cnt = dwell_cnt_r;

`ifdef RGB_DEC_STUCK_EN
  logic err_stuck_r;
  logic set_stuck_s;

  assign set_stuck_s = in_phase_s && !phase_chg_s && tick &&
                       (dwell_cnt_r == CNT_W'(STUCK_TICKS - 1));

  // Watchdog: flag a phase whose dwell reaches the stuck limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_stuck_r <= 1'b0;
    end else begin
      err_stuck_r <= set_stuck_s ? 1'b1 : (err_clr ? 1'b0 : err_stuck_r);
    end
  end

  assign err_stuck = err_stuck_r;
`else
  assign err_stuck = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_phase_decoder.sv
// Directed self-checking bench for rgb_phase_decoder.
module tb_rgb_phase_decoder;

  localparam logic [5:0] PAT_OFF = 6'b000_000;
  localparam logic [5:0] PAT_P1  = 6'b100_010;
  localparam logic [5:0] PAT_P2  = 6'b100_110;
  localparam logic [5:0] PAT_BR  = 6'b100_100;
  localparam logic [5:0] PAT_P4  = 6'b010_100;
  localparam logic [5:0] PAT_P5  = 6'b110_100;
  localparam logic [5:0] PAT_P2B = 6'b101_110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       led4_r = 1'b0, led4_g = 1'b0, led4_b = 1'b0;
  logic       led5_r = 1'b0, led5_g = 1'b0, led5_b = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] phase;
  logic       phase_chg;
  logic [3:0] dwell_cnt;
  logic [7:0] cycle_cnt;
  logic       err_illegal, err_seq, err_timing, err_stuck;

  int total = 0;
  int bad   = 0;

  rgb_phase_decoder dut (
    .clk(clk), .rst(rst), .tick(tick),
    .led4_r(led4_r), .led4_g(led4_g), .led4_b(led4_b),
    .led5_r(led5_r), .led5_g(led5_g), .led5_b(led5_b),
    .err_clr(err_clr), .phase(phase), .phase_chg(phase_chg),
    .dwell_cnt(dwell_cnt), .cycle_cnt(cycle_cnt),
    .err_illegal(err_illegal), .err_seq(err_seq),
    .err_timing(err_timing), .err_stuck(err_stuck)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pat(input logic [5:0] p);
    {led4_r, led4_g, led4_b, led5_r, led5_g, led5_b} = p;
  endtask

  // Drive a pattern and wait until the decoded phase has updated
  task automatic go(input logic [5:0] p);
    set_pat(p);
    cyc(2);
  endtask

  // Tick every 4 clk
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(3);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    total++; if (phase !== 3'd0) begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
    total++; if ({phase_chg, dwell_cnt, cycle_cnt} !== 13'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d/%0d want=0/0/0", phase_chg, dwell_cnt, cycle_cnt); end
    total++; if ({err_illegal, err_seq, err_timing, err_stuck} !== 4'b0000) begin bad++; $display("FAIL reset_errs got=%b want=0000", {err_illegal, err_seq, err_timing, err_stuck}); end
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_nominal();
    go(PAT_P1);
    total++; if (phase !== 3'd1) begin bad++; $display("FAIL nom_p1 got=%0d want=1", phase); end
    total++; if (phase_chg !== 1'b1) begin bad++; $display("FAIL nom_chg_p1 got=%0d want=1", phase_chg); end
    cyc(1);
    total++; if (phase_chg !== 1'b0) begin bad++; $display("FAIL nom_chg_pulse got=%0d want=0", phase_chg); end
    ticks(5);
    total++; if (dwell_cnt !== 4'd5) begin bad++; $display("FAIL nom_dwell_p1 got=%0d want=5", dwell_cnt); end
    go(PAT_P2);
    total++; if (phase !== 3'd2 || phase_chg !== 1'b1) begin bad++; $display("FAIL nom_p2 got=%0d/%0d want=2/1", phase, phase_chg); end
    ticks(1);
    go(PAT_BR);
    total++; if (phase !== 3'd3) begin bad++; $display("FAIL nom_p3 got=%0d want=3", phase); end
    ticks(1);
    go(PAT_P4);
    total++; if (phase !== 3'd4) begin bad++; $display("FAIL nom_p4 got=%0d want=4", phase); end
    ticks(5);
    go(PAT_P5);
    total++; if (phase !== 3'd5) begin bad++; $display("FAIL nom_p5 got=%0d want=5", phase); end
    ticks(1);
    go(PAT_BR);
    total++; if (phase !== 3'd6) begin bad++; $display("FAIL nom_p6 got=%0d want=6", phase); end
    ticks(1);
    go(PAT_P1);
    total++; if (phase !== 3'd1 || phase_chg !== 1'b1) begin bad++; $display("FAIL nom_wrap got=%0d/%0d want=1/1", phase, phase_chg); end
    total++; if (cycle_cnt !== 8'd1) begin bad++; $display("FAIL nom_cycle got=%0d want=1", cycle_cnt); end
    total++; if (dwell_cnt !== 4'd0) begin bad++; $display("FAIL nom_dwell_restart got=%0d want=0", dwell_cnt); end
    total++; if ({err_illegal, err_seq, err_timing} !== 3'b000) begin bad++; $display("FAIL nom_errs got=%b want=000", {err_illegal, err_seq, err_timing}); end
  endtask

  task automatic test_illegal();
    go(PAT_OFF);
    total++; if (phase !== 3'd0) begin bad++; $display("FAIL ill_off got=%0d want=0", phase); end
    go(PAT_P1);
    ticks(5);
    go(PAT_P2);
    go(PAT_P2B);
    total++; if (phase !== 3'd7 || err_illegal !== 1'b1) begin bad++; $display("FAIL ill_detect got=%0d/%0d want=7/1", phase, err_illegal); end
    go(PAT_OFF);
    total++; if (phase !== 3'd0 || err_illegal !== 1'b1) begin bad++; $display("FAIL ill_exit got=%0d/%0d want=0/1", phase, err_illegal); end
    pulse_clr();
    total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL ill_clr got=%0d want=0", err_illegal); end
  endtask

  task automatic test_seq();
    go(PAT_P1);
    go(PAT_BR);
    total++; if (phase !== 3'd7 || err_seq !== 1'b1 || err_illegal !== 1'b0) begin bad++; $display("FAIL seq_jump got=%0d/%0d/%0d want=7/1/0", phase, err_seq, err_illegal); end
    go(PAT_OFF);
    pulse_clr();
    total++; if (err_seq !== 1'b0) begin bad++; $display("FAIL seq_clr got=%0d want=0", err_seq); end
  endtask

  task automatic test_timing();
    go(PAT_P1);
    ticks(3);
    go(PAT_P2);
    total++; if (phase !== 3'd2 || err_timing !== 1'b1 || err_seq !== 1'b0) begin bad++; $display("FAIL tim_short got=%0d/%0d/%0d want=2/1/0", phase, err_timing, err_seq); end
    pulse_clr();
    total++; if (err_timing !== 1'b0) begin bad++; $display("FAIL tim_clr got=%0d want=0", err_timing); end
    // P2 left with zero ticks while err_clr pulses on the same edge
    set_pat(PAT_BR);
    cyc(1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    total++; if (phase !== 3'd3 || err_timing !== 1'b1) begin bad++; $display("FAIL tim_clr_race got=%0d/%0d want=3/1", phase, err_timing); end
    cyc(1);
    total++; if (err_timing !== 1'b1) begin bad++; $display("FAIL tim_sticky got=%0d want=1", err_timing); end
  endtask

  task automatic test_mid_reset();
    go(PAT_OFF);
    go(PAT_P1);
    ticks(5);
    go(PAT_P2);
    ticks(1);
    go(PAT_BR);
    ticks(1);
    go(PAT_P4);
    ticks(3);
    total++; if (phase !== 3'd4 || dwell_cnt !== 4'd3 || cycle_cnt !== 8'd1 || err_timing !== 1'b1) begin bad++; $display("FAIL rst_pre got=%0d/%0d/%0d/%0d want=4/3/1/1", phase, dwell_cnt, cycle_cnt, err_timing); end
    rst = 1'b1;
    #1;
    total++; if (phase !== 3'd0 || dwell_cnt !== 4'd0 || cycle_cnt !== 8'd0) begin bad++; $display("FAIL rst_async got=%0d/%0d/%0d want=0/0/0", phase, dwell_cnt, cycle_cnt); end
    total++; if ({phase_chg, err_illegal, err_seq, err_timing, err_stuck} !== 5'b00000) begin bad++; $display("FAIL rst_async_flags got=%b want=00000", {phase_chg, err_illegal, err_seq, err_timing, err_stuck}); end
    set_pat(PAT_OFF);
    cyc(2);
    rst = 1'b0;
    go(PAT_P2);
    total++; if (phase !== 3'd7 || err_seq !== 1'b1) begin bad++; $display("FAIL rst_first_p2 got=%0d/%0d want=7/1", phase, err_seq); end
  endtask

  task automatic test_stuck();
    go(PAT_OFF);
    pulse_clr();
    go(PAT_P1);
    ticks(5);
    go(PAT_P2);
    ticks(1);
    go(PAT_BR);
    ticks(1);
    go(PAT_P4);
    ticks(7);
    total++; if (dwell_cnt !== 4'd7 || err_stuck !== 1'b0 || err_timing !== 1'b0) begin bad++; $display("FAIL stuck_pre got=%0d/%0d/%0d want=7/0/0", dwell_cnt, err_stuck, err_timing); end
    ticks(1);
    total++; if (dwell_cnt !== 4'd8 || phase !== 3'd4) begin bad++; $display("FAIL stuck_dwell got=%0d/%0d want=8/4", dwell_cnt, phase); end
`ifdef RGB_DEC_STUCK_EN
    total++; if (err_stuck !== 1'b1) begin bad++; $display("FAIL stuck_flag got=%0d want=1", err_stuck); end
`else
    total++; if (err_stuck !== 1'b0) begin bad++; $display("FAIL stuck_flag got=%0d want=0", err_stuck); end
`endif
    ticks(8);
    total++; if (dwell_cnt !== 4'd15 || phase !== 3'd4) begin bad++; $display("FAIL dwell_sat got=%0d/%0d want=15/4", dwell_cnt, phase); end
  endtask

  task automatic test_tick_drop();
    go(PAT_OFF);
    set_pat(PAT_P1);
    cyc(1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    total++; if (phase !== 3'd1 || dwell_cnt !== 4'd0) begin bad++; $display("FAIL tick_drop got=%0d/%0d want=1/0", phase, dwell_cnt); end
    ticks(2);
    total++; if (dwell_cnt !== 4'd2) begin bad++; $display("FAIL tick_after_drop got=%0d want=2", dwell_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_illegal();
    test_seq();
    test_timing();
    test_mid_reset();
    test_stuck();
    test_tick_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
